// File: rtl/rtlmem_nrnw_lvt_pkg.sv
// rtlmem_nrnw_lvt_pkg: clear-FSM encoding, read-latency limits and clog2 shared by the LVT RAM.
package rtlmem_nrnw_lvt_pkg;
    typedef enum logic {CLR_IDLE = 1'b0, CLR_RUN = 1'b1} clr_state_t;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rtlmem_nrnw_lvt_if.sv
// rtlmem_nrnw_lvt_if: user-side write/read/clear bundle of the LVT multi-port RAM.
interface rtlmem_nrnw_lvt_if #(
    parameter int G_NWR   = 2,
    parameter int G_NRD   = 2,
    parameter int G_ADDR  = 10,
    parameter int G_WIDTH = 16
);
    logic                       clren;
    logic                       clrrdy;
    logic [G_NWR-1:0]           mem_we;
    logic [G_NWR*G_ADDR-1:0]    mem_wa;
    logic [G_NWR*G_WIDTH-1:0]   mem_di;
    logic [G_NRD-1:0]           mem_re;
    logic [G_NRD*G_ADDR-1:0]    mem_ra;
    logic [G_NRD*G_WIDTH-1:0]   mem_do;
    logic [G_NRD-1:0]           mem_dv;
    modport master (output clren, mem_we, mem_wa, mem_di, mem_re, mem_ra, input clrrdy, mem_do, mem_dv);
    modport slave  (input clren, mem_we, mem_wa, mem_di, mem_re, mem_ra, output clrrdy, mem_do, mem_dv);
endinterface

// File: rtl/rtlmem_nrnw_lvt_bank.sv
// rtlmem_nrnw_lvt_bank: simple dual-port 1W1R RAM with synchronous read, old data on collision.
module rtlmem_nrnw_lvt_bank #(
    parameter int G_ADDR  = 10,
    parameter int G_WIDTH = 16
) (
    input  logic               clk,
    input  logic               we,
    input  logic [G_ADDR-1:0]  wa,
    input  logic [G_WIDTH-1:0] wd,
    input  logic               re,
    input  logic [G_ADDR-1:0]  ra,
    output logic [G_WIDTH-1:0] rd
);
    logic [G_WIDTH-1:0] mem [2**G_ADDR];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/rtlmem_nrnw_lvt.sv
// rtlmem_nrnw_lvt: G_NWR-write / G_NRD-read RAM built from 1W1R banks plus a live-value table.
// Optional RTLMEM_NRNW_WRBYPASS_EN forwards same-cycle write data to colliding reads.
module rtlmem_nrnw_lvt
    import rtlmem_nrnw_lvt_pkg::*;
#(
    parameter int                 G_NWR     = 2,
    parameter int                 G_NRD     = 2,
    parameter int                 G_ADDR    = 10,
    parameter int                 G_WIDTH   = 16,
    parameter int                 G_RD_LAT  = 3,
    parameter logic [G_WIDTH-1:0] G_RST_VAL = '0
) (
    input logic            clk1x,
    input logic            rst1x,
    rtlmem_nrnw_lvt_if.slave m
);
    localparam int DEPTH = 2**G_ADDR;
    localparam int LW    = G_NWR > 1 ? clog2(G_NWR) : 1;
    localparam int LAT   = G_RD_LAT < RD_LAT_MIN ? RD_LAT_MIN : G_RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : G_RD_LAT;

    clr_state_t        state, state_nx;
    logic [G_ADDR-1:0] cnt;
    logic              clearing;

    always_ff @(posedge clk1x or posedge rst1x)
        if (rst1x) begin
            state <= CLR_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= clearing ? cnt + 1'b1 : '0;
        end

    always_comb
        state_nx = state == CLR_RUN ? (&cnt ? CLR_IDLE : CLR_RUN) : (m.clren ? CLR_RUN : CLR_IDLE);

    always_comb begin
        clearing = state == CLR_RUN;
        m.clrrdy = state == CLR_IDLE;
    end

    // The sweep takes over write port 0 and silences the others.
    logic [G_NWR-1:0]   wen;
    logic [G_ADDR-1:0]  wa [G_NWR];
    logic [G_WIDTH-1:0] wd [G_NWR];
    always_comb
        for (int i = 0; i < G_NWR; i++) begin
            wen[i] = clearing ? i == 0 : m.mem_we[i];
            wa[i]  = clearing ? cnt : m.mem_wa[i*G_ADDR +: G_ADDR];
            wd[i]  = clearing ? G_RST_VAL : m.mem_di[i*G_WIDTH +: G_WIDTH];
        end

    logic [LW-1:0] lvt_q [G_NRD];
    if (G_NWR > 1) begin : g_lvt
        logic [LW-1:0] lvt [DEPTH];
        always_ff @(posedge clk1x) begin
            for (int i = 0; i < G_NWR; i++)
                if (wen[i]) lvt[wa[i]] <= LW'(i);
            for (int i = 0; i < G_NRD; i++)
                if (m.mem_re[i]) lvt_q[i] <= lvt[m.mem_ra[i*G_ADDR +: G_ADDR]];
        end
    end else begin : g_no_lvt
        always_comb lvt_q = '{default: '0};
    end

    logic [G_WIDTH-1:0] bq [G_NWR][G_NRD];
    for (genvar w = 0; w < G_NWR; w++) begin : g_w
        for (genvar r = 0; r < G_NRD; r++) begin : g_r
            rtlmem_nrnw_lvt_bank #(.G_ADDR(G_ADDR), .G_WIDTH(G_WIDTH)) u_bank (
                .clk (clk1x),
                .we  (wen[w]),
                .wa  (wa[w]),
                .wd  (wd[w]),
                .re  (m.mem_re[r]),
                .ra  (m.mem_ra[r*G_ADDR +: G_ADDR]),
                .rd  (bq[w][r])
            );
        end
    end

    logic [G_NRD-1:0] v1;
    always_ff @(posedge clk1x or posedge rst1x)
        if (rst1x) v1 <= '0;
        else v1 <= m.mem_re;

`ifdef RTLMEM_NRNW_WRBYPASS_EN
    logic [G_NWR-1:0]   wv_q;
    logic [G_ADDR-1:0]  wa_q [G_NWR];
    logic [G_WIDTH-1:0] wd_q [G_NWR];
    logic [G_ADDR-1:0]  ra_q [G_NRD];
    always_ff @(posedge clk1x) begin
        wv_q <= clearing ? '0 : m.mem_we;
        for (int i = 0; i < G_NWR; i++) begin
            wa_q[i] <= wa[i];
            wd_q[i] <= wd[i];
        end
        for (int i = 0; i < G_NRD; i++)
            ra_q[i] <= m.mem_ra[i*G_ADDR +: G_ADDR];
    end
`endif

    logic [G_NRD*G_WIDTH-1:0] sel;
    always_comb
        for (int i = 0; i < G_NRD; i++) begin
            sel[i*G_WIDTH +: G_WIDTH] = bq[lvt_q[i]][i];
`ifdef RTLMEM_NRNW_WRBYPASS_EN
            for (int j = 0; j < G_NWR; j++)
                if (wv_q[j] && wa_q[j] == ra_q[i]) sel[i*G_WIDTH +: G_WIDTH] = wd_q[j];
`endif
        end

    logic [G_NRD*G_WIDTH-1:0] tap_d, hold;
    logic [G_NRD-1:0]         tap_v;
    if (LAT == 1) begin : g_lat1
        assign tap_d = sel;
        assign tap_v = v1;
    end else begin : g_latn
        logic [G_NRD*G_WIDTH-1:0] dq [LAT-1];
        logic [G_NRD-1:0]         vq [LAT-1];
        always_ff @(posedge clk1x or posedge rst1x)
            if (rst1x) vq <= '{default: '0};
            else begin
                vq[0] <= v1;
                for (int i = 1; i < LAT-1; i++) vq[i] <= vq[i-1];
            end
        always_ff @(posedge clk1x) begin
            dq[0] <= sel;
            for (int i = 1; i < LAT-1; i++) dq[i] <= dq[i-1];
        end
        assign tap_d = dq[LAT-2];
        assign tap_v = vq[LAT-2];
    end

    // Each port keeps showing its last completed read until the next one lands.
    always_ff @(posedge clk1x or posedge rst1x)
        if (rst1x) hold <= {G_NRD{G_RST_VAL}};
        else hold <= m.mem_do;

    always_comb begin
        m.mem_dv = tap_v;
        for (int i = 0; i < G_NRD; i++)
            m.mem_do[i*G_WIDTH +: G_WIDTH] = tap_v[i] ? tap_d[i*G_WIDTH +: G_WIDTH] : hold[i*G_WIDTH +: G_WIDTH];
    end
endmodule

// File: tb/tb_rtlmem_nrnw_lvt.sv
// tb_rtlmem_nrnw_lvt: directed and randomized checks of the LVT RAM against an array-based memory model.
module tb_rtlmem_nrnw_lvt;
    localparam int NWR = 2, NRD = 2, AW = 4, DW = 16, LAT = 3, DEPTH = 16, HN = 2048;
`ifdef RTLMEM_NRNW_WRBYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk1x = 1'b0;
    logic rst1x = 1'b1;
    always #5 clk1x = ~clk1x;

    rtlmem_nrnw_lvt_if #(.G_NWR(NWR), .G_NRD(NRD), .G_ADDR(AW), .G_WIDTH(DW)) m ();
    rtlmem_nrnw_lvt #(
        .G_NWR(NWR), .G_NRD(NRD), .G_ADDR(AW), .G_WIDTH(DW), .G_RD_LAT(LAT), .G_RST_VAL('0)
    ) dut (
        .clk1x (clk1x),
        .rst1x (rst1x),
        .m     (m)
    );

    int n_chk = 0, n_pass = 0, cyc = 0, clr_left = 0;
    logic [DW-1:0] mdl [DEPTH];
    bit            hre [NRD][HN];
    bit            hx  [NRD][HN];
    logic [DW-1:0] hv  [NRD][HN];
    logic [DW-1:0] last [NRD];
    bit            known [NRD];

    function automatic logic [NRD-1:0] exp_dv();
        int j = cyc - LAT;
        exp_dv = '0;
        if (j >= 0) for (int p = 0; p < NRD; p++) exp_dv[p] = hre[p][j];
    endfunction

    function automatic logic [NRD*DW-1:0] exp_do();
        exp_do = {last[1], last[0]};
    endfunction

    task automatic rst_on();
        rst1x = 1'b1;
        m.clren = 1'b0; m.mem_we = '0; m.mem_wa = '0; m.mem_di = '0; m.mem_re = '0; m.mem_ra = '0;
        for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int i = 0; i < HN; i++) hre[p][i] = 1'b0;
            last[p] = '0;
            known[p] = 1'b1;
        end
        clr_left = DEPTH;
        #1;
    endtask

    // Drives one cycle and advances the model: reads see pre-write contents (or the
    // highest writing port with bypass), writes land only while no sweep is running.
    task automatic step(input logic [1:0] we, input int wa0, input int wa1, input int d0, input int d1,
                        input logic [1:0] re, input int ra0, input int ra1, input logic clr);
        logic [AW-1:0] aw [2];
        logic [AW-1:0] ar [2];
        logic [DW-1:0] dd [2];
        logic [DW-1:0] v;
        bit rdy;
        int j;
        aw[0] = AW'(wa0); aw[1] = AW'(wa1); ar[0] = AW'(ra0); ar[1] = AW'(ra1);
        dd[0] = DW'(d0); dd[1] = DW'(d1);
        m.clren = clr; m.mem_we = we; m.mem_wa = {aw[1], aw[0]}; m.mem_di = {dd[1], dd[0]};
        m.mem_re = re; m.mem_ra = {ar[1], ar[0]};
        rdy = clr_left == 0;
        for (int p = 0; p < NRD; p++) begin
            v = mdl[ar[p]];
            if (BYP && rdy)
                for (int w = 0; w < NWR; w++) if (we[w] && aw[w] == ar[p]) v = dd[w];
            hre[p][cyc] = re[p]; hx[p][cyc] = !rdy; hv[p][cyc] = v;
        end
        if (rdy) begin
            for (int w = 0; w < NWR; w++) if (we[w]) mdl[aw[w]] = dd[w];
            if (clr) begin
                for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
                clr_left = DEPTH;
            end
        end else clr_left--;
        @(posedge clk1x); #1;
        cyc++;
        j = cyc - LAT;
        if (j >= 0)
            for (int p = 0; p < NRD; p++)
                if (hre[p][j]) begin
                    if (hx[p][j]) known[p] = 1'b0;
                    else begin last[p] = hv[p][j]; known[p] = 1'b1; end
                end
    endtask

    task automatic step_idle();
        step(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic test_readback(input string tag);
        for (int c = 0; c < DEPTH + LAT; c++) begin
            step(2'b00, 0, 0, 0, 0, c < DEPTH ? 2'b11 : 2'b00, c, DEPTH - 1 - c, 1'b0);
            n_chk++;
            if (m.mem_dv !== exp_dv()) $display("FAIL %s_dv c=%0d got=%b exp=%b", tag, c, m.mem_dv, exp_dv());
            else n_pass++;
            if (known[0] && known[1]) begin
                n_chk++;
                if (m.mem_do !== exp_do()) $display("FAIL %s_do c=%0d got=%h exp=%h", tag, c, m.mem_do, exp_do());
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        int n = 0;
        rst_on();
        repeat (2) @(posedge clk1x);
        #1;
        n_chk++; if (m.mem_dv !== 2'b00) $display("FAIL reset_dv got=%b exp=00", m.mem_dv); else n_pass++;
        n_chk++; if (m.mem_do !== 32'h0) $display("FAIL reset_do got=%h exp=0", m.mem_do); else n_pass++;
        n_chk++; if (m.clrrdy !== 1'b0) $display("FAIL reset_clrrdy got=%b exp=0", m.clrrdy); else n_pass++;
        rst1x = 1'b0;
        while (m.clrrdy !== 1'b1 && n < 100) begin step_idle(); n++; end
        n_chk++; if (n != DEPTH) $display("FAIL reset_sweep_len got=%0d exp=%0d", n, DEPTH); else n_pass++;
        test_readback("reset_readback");
    endtask

    task automatic test_two_port();
        step(2'b11, 5, 9, 'hAAAA, 'h5555, 2'b00, 0, 0, 1'b0);
        step(2'b00, 0, 0, 0, 0, 2'b11, 5, 9, 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            n_chk++;
            if (m.mem_dv !== (k == LAT ? 2'b11 : 2'b00)) $display("FAIL two_port_dv k=%0d got=%b", k, m.mem_dv);
            else n_pass++;
            if (k >= LAT) begin
                n_chk++;
                if (m.mem_do !== 32'h5555_AAAA) $display("FAIL two_port_do k=%0d got=%h exp=5555aaaa", k, m.mem_do);
                else n_pass++;
            end
            step_idle();
        end
    endtask

    task automatic test_same_addr();
        step(2'b11, 7, 7, 'h1111, 'h2222, 2'b00, 0, 0, 1'b0);
        step(2'b00, 0, 0, 0, 0, 2'b11, 7, 7, 1'b0);
        repeat (LAT - 1) step_idle();
        n_chk++; if (m.mem_dv !== 2'b11) $display("FAIL same_addr_dv got=%b exp=11", m.mem_dv); else n_pass++;
        n_chk++; if (m.mem_do !== 32'h2222_2222) $display("FAIL same_addr_do got=%h exp=22222222", m.mem_do); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp = BYP ? 16'hBEEF : mdl[3];
        step(2'b01, 3, 0, 'hBEEF, 0, 2'b01, 3, 0, 1'b0);
        repeat (LAT - 1) step_idle();
        n_chk++; if (m.mem_dv !== 2'b01) $display("FAIL bypass_dv got=%b exp=01", m.mem_dv); else n_pass++;
        n_chk++; if (m.mem_do[DW-1:0] !== exp) $display("FAIL bypass_do got=%h exp=%h", m.mem_do[DW-1:0], exp); else n_pass++;
        step(2'b00, 0, 0, 0, 0, 2'b10, 0, 3, 1'b0);
        repeat (LAT - 1) step_idle();
        n_chk++; if (m.mem_do[2*DW-1:DW] !== 16'hBEEF) $display("FAIL bypass_after got=%h exp=beef", m.mem_do[2*DW-1:DW]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            step(2'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 65535), $urandom_range(0, 65535), 2'($urandom),
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1'b0);
            n_chk++;
            if (m.mem_dv !== exp_dv()) $display("FAIL b2b_dv c=%0d got=%b exp=%b", c, m.mem_dv, exp_dv());
            else n_pass++;
            n_chk++;
            if (m.mem_do !== exp_do()) $display("FAIL b2b_do c=%0d got=%h exp=%h", c, m.mem_do, exp_do());
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        int n = 0;
        step(2'b01, 2, 0, 'h1234, 0, 2'b01, 2, 0, 1'b1);
        n_chk++; if (m.clrrdy !== 1'b0) $display("FAIL clear_start got=%b exp=0", m.clrrdy); else n_pass++;
        while (m.clrrdy !== 1'b1 && n < 100) begin
            step(2'b11, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                 $urandom_range(1, 65535), $urandom_range(1, 65535), 2'($urandom),
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), n == 4);
            n++;
            n_chk++;
            if (m.mem_dv !== exp_dv()) $display("FAIL clear_dv n=%0d got=%b exp=%b", n, m.mem_dv, exp_dv());
            else n_pass++;
        end
        n_chk++; if (n != DEPTH) $display("FAIL clear_sweep_len got=%0d exp=%0d", n, DEPTH); else n_pass++;
        test_readback("clear_readback");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int k = 0; k < 4; k++)
            step(2'b11, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                 $urandom_range(1, 65535), $urandom_range(1, 65535), 2'b11,
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1'b0);
        rst_on();
        n_chk++; if (m.mem_dv !== 2'b00) $display("FAIL rst_mid_dv got=%b exp=00", m.mem_dv); else n_pass++;
        n_chk++; if (m.mem_do !== 32'h0) $display("FAIL rst_mid_do got=%h exp=0", m.mem_do); else n_pass++;
        n_chk++; if (m.clrrdy !== 1'b0) $display("FAIL rst_mid_clrrdy got=%b exp=0", m.clrrdy); else n_pass++;
        @(posedge clk1x);
        #1;
        rst1x = 1'b0;
        while (m.clrrdy !== 1'b1 && n < 100) begin
            step_idle();
            n++;
            n_chk++;
            if (m.mem_dv !== 2'b00) $display("FAIL rst_mid_flush n=%0d got=%b exp=00", n, m.mem_dv);
            else n_pass++;
        end
        n_chk++; if (n != DEPTH) $display("FAIL rst_mid_sweep_len got=%0d exp=%0d", n, DEPTH); else n_pass++;
        test_readback("rst_mid_readback");
    endtask

    initial begin
        test_reset();
        test_two_port();
        test_same_addr();
        test_bypass();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
